irq_responder: RTL

//   CPU-side end of the intc IRQ/IACK/ADDR handshake; instantiated inside mips4 between intc and the PC-select mux.

---
 rtl/irq_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/irq_responder.sv
`default_nettype none
// ============================================================================
// Module   : irq_responder
// Purpose  : CPU-side end of the intc IRQ/IACK/ADDR handshake. Samples irq at
//            instruction boundaries, saves the return PC (EPC), redirects
//            fetch to the ISR vector and acknowledges the request. On eret it
//            redirects fetch back to the saved EPC and re-arms.
// Ports    : clk, rst            - clock / synchronous active-high reset
//            irq, irq_addr       - level request and ISR vector from intc
//            boundary, ret_pc    - instruction retiring, PC of its successor
//            eret                - retiring instruction is eret
//            ie_we, ie_wd        - interrupt-enable write port
//            irq_ack             - one-cycle acknowledge to intc
//            redirect,
//            redirect_pc         - one-cycle fetch redirect and its target
//            epc                 - top-of-stack saved return PC
//            in_isr, ie          - servicing flag, interrupt-enable flag
//            nest_lvl            - active nesting level
// Config   : IRQ_NEST_EN - when defined, EPC becomes a NEST_DEPTH-entry stack
//            and interrupts may nest; otherwise a single EPC register is used
//            and nest_lvl is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module irq_responder #(
    parameter int PC_W       = 32,
    parameter bit IE_RESET   = 1'b1,
    parameter int NEST_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            irq,
    input  logic [PC_W-1:0]                 irq_addr,
    input  logic                            boundary,
    input  logic [PC_W-1:0]                 ret_pc,
    input  logic                            eret,
    input  logic                            ie_we,
    input  logic                            ie_wd,
    output logic                            irq_ack,
    output logic                            redirect,
    output logic [PC_W-1:0]                 redirect_pc,
    output logic [PC_W-1:0]                 epc,
    output logic                            in_isr,
    output logic                            ie,
    output logic [$clog2(NEST_DEPTH+1)-1:0] nest_lvl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAKE = 2'd1,
        S_ISR  = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_irq_ack;
    logic              r_redirect;
    logic [PC_W-1:0]   r_redirect_pc;
    logic [PC_W-1:0]   r_epc;
    logic              r_in_isr;
    logic              r_ie;

    logic              w_req;
    logic              w_ret;
    logic              w_take;
    logic              w_nest_ok;
    logic              w_last_level;
    logic [PC_W-1:0]   w_epc_below;

    // eret on the same boundary suppresses acceptance, so eret always wins.
    assign w_req  = irq & r_ie & boundary & ~eret;
    assign w_ret  = boundary & eret;
    assign w_take = w_req & ((r_state == S_IDLE) | ((r_state == S_ISR) & w_nest_ok));

`ifdef IRQ_NEST_EN
    localparam int LVL_W = $clog2(NEST_DEPTH + 1);
    localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    logic [PC_W-1:0]  r_stack [NEST_DEPTH];
    logic [LVL_W-1:0] r_lvl;

    assign w_nest_ok    = (r_lvl < LVL_W'(NEST_DEPTH));
    assign w_last_level = (r_lvl == LVL_W'(1));
    // Entry that becomes top-of-stack after a pop (only meaningful at lvl>=2).
    assign w_epc_below  = r_stack[IDX_W'(r_lvl - LVL_W'(2))];
    assign nest_lvl     = r_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl <= '0;
        end else if (w_take) begin
            r_lvl <= r_lvl + LVL_W'(1);
        end else if (r_state == S_RET) begin
            r_lvl <= r_lvl - LVL_W'(1);
        end
    end

    // Stack contents are don't-care until pushed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_stack[IDX_W'(r_lvl)] <= ret_pc;
        end
    end
`else
    assign w_nest_ok    = 1'b0;
    assign w_last_level = 1'b1;
    assign w_epc_below  = r_epc;
    assign nest_lvl     = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_irq_ack     <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_epc         <= '0;
            r_in_isr      <= 1'b0;
            r_ie          <= IE_RESET;
        end else begin
            // Ack and redirect are single-cycle pulses.
            r_irq_ack  <= 1'b0;
            r_redirect <= 1'b0;

            if (ie_we) begin
                r_ie <= ie_wd;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state       <= S_TAKE;
                        r_irq_ack     <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= irq_addr;
                        r_epc         <= ret_pc;
                        r_in_isr      <= 1'b1;
                    end
                end
                // Pulse cycle; younger stages are being flushed, ignore inputs.
                S_TAKE: begin
                    r_state <= S_ISR;
                end
                S_ISR: begin
                    if (w_ret) begin
                        r_state       <= S_RET;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= r_epc;
                    end else if (w_take) begin
                        r_state       <= S_TAKE;
                        r_irq_ack     <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= irq_addr;
                        r_epc         <= ret_pc;
                    end
                end
                S_RET: begin
                    if (w_last_level) begin
                        r_in_isr <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_epc   <= w_epc_below;
                        r_state <= S_ISR;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq_ack     = r_irq_ack;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign epc         = r_epc;
    assign in_isr      = r_in_isr;
    assign ie          = r_ie;

endmodule
`default_nettype wire
